loop_sequencer: RTL and testbench
=================================

LOOP_SEQUENCER -- requirements
Module: loop_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-004 SHALL have port down, input, 1 bit: 0 counts up, 1 counts down; latched on start acceptance.
REQ-005 SHALL have port mod_value, input, 3 bits: terminal count M, giving a loop length of M+1; latched on start acceptance.
REQ-006 SHALL have port loops, input, 3 bits: loops per run, L; value 0 means 8; latched on start acceptance.
REQ-007 SHALL have port pause, input, 1 bit, present only when LOOP_PAUSE_EN is defined.
REQ-008 SHALL have port count, output, 3 bits: current counter value.
REQ-009 SHALL have port loop_idx, output, 3 bits: zero-based index of the current loop.
REQ-010 SHALL have port loopStart, output, 1 bit: high in the first cycle of each loop.
REQ-011 SHALL have port loopEnd, output, 1 bit: high in the last cycle of each loop.
REQ-012 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at run completion.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 IDLE with start=1 at a clock edge SHALL latch down, mod_value and loops, clear loop_idx, load count with the start value (0 when up, M when down), and enter RUN.
REQ-016 The first RUN cycle SHALL present the start value, giving a start-to-first-count latency of 1 cycle.
REQ-017 In RUN, count SHALL step by +1 (up) or -1 (down) each cycle; on reaching the end value (M when up, 0 when down) it SHALL wrap to the start value on the next edge.
REQ-018 loopStart SHALL equal (state==RUN && count==start value); loopEnd SHALL equal (state==RUN && count==end value).
REQ-019 When M=0, every RUN cycle SHALL be one full loop, with loopStart and loopEnd both high.
REQ-020 On loopEnd with loop_idx < L-1, loop_idx SHALL increment at the same edge as the count wrap.
REQ-021 On loopEnd with loop_idx == L-1, the FSM SHALL enter DONE, and count and loop_idx SHALL hold.
REQ-022 A run SHALL occupy exactly L*(M+1) RUN cycles.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 Changes to down, mod_value or loops during RUN SHALL have no effect.
REQ-026 In IDLE, count and loop_idx SHALL hold their last values, and loopStart and loopEnd SHALL be 0.

Reset
REQ-027 reset=0 SHALL force state IDLE, count=0, loop_idx=0, busy=0, done=0, loopStart=0 and loopEnd=0 immediately, regardless of clk.
REQ-028 Reset asserted mid-run SHALL abort the run with no done pulse.
REQ-029 After reset deassertion, the first start SHALL be accepted on the next edge.

Configuration
REQ-030 When LOOP_PAUSE_EN is defined, pause=1 in RUN SHALL freeze count, loop_idx and state, and SHALL force loopStart and loopEnd to 0 for those cycles; pause SHALL be ignored in IDLE and DONE.
REQ-031 When LOOP_PAUSE_EN is undefined, the pause port SHALL be absent and RUN SHALL never stall.

Structure
REQ-032 The state enum (IDLE/RUN/DONE), the CNT_W=3 constant and the loops-zero-means-8 constant SHALL live in the shared package loop_seq_pkg.
REQ-033 The counting datapath SHALL be one sub-module, mod_updown_cnt, with load, enable, down and mod inputs and count and terminal outputs; the FSM and loop bookkeeping SHALL stay in loop_sequencer.

Verification
REQ-034 Bench SHALL cover: up, M=5, L=2 -> count 0..5,0..5 over 12 RUN cycles; loopStart at counts 0, loopEnd at counts 5; done in cycle 13.
REQ-035 Bench SHALL cover: down, M=3, L=1 -> count 3,2,1,0; loopStart with 3, loopEnd with 0; done in the next cycle; count holds 0 in IDLE.
REQ-036 Bench SHALL cover: M=0, L=3 -> 3 RUN cycles with count 0; loopStart=loopEnd=1 each cycle; loop_idx 0,1,2.
REQ-037 Bench SHALL cover: L=0, M=1, up -> 16 RUN cycles; loop_idx reaches 7 before done.
REQ-038 Bench SHALL cover: start pulsed and mod_value changed mid-run -> run length and count sequence unchanged.
REQ-039 Bench SHALL cover: reset low at RUN cycle 4 -> all outputs 0 asynchronously, no done, and a fresh start is accepted; with LOOP_PAUSE_EN, 3 pause cycles extend the run by exactly 3 cycles.

Source files
------------

// File: rtl/loop_seq_pkg.sv
// Shared definitions for the loop sequencer: FSM state encoding, counter
// width and the loops-field encoding where a value of zero requests 8 loops.
package loop_seq_pkg;

   localparam int CNT_W          = 3;
   localparam int LOOPS_ZERO_VAL = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of loops a run performs for a given loops field (0 encodes 8).
   function automatic logic [CNT_W:0] loops_count(input logic [CNT_W-1:0] l);
      return (l == '0) ? (CNT_W+1)'(LOOPS_ZERO_VAL) : {1'b0, l};
   endfunction

endpackage

// File: rtl/mod_updown_cnt.sv
// Modulo up/down counter. Load places the start value (0 up, mod down);
// enable steps towards the end value (mod up, 0 down) and wraps back to the
// start value on the edge after terminal is reached.
module mod_updown_cnt
   import loop_seq_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             enable,
   input  logic             down,
   input  logic [CNT_W-1:0] mod,
   output logic [CNT_W-1:0] count,
   output logic             terminal
);

   logic [CNT_W-1:0] start_val;

   assign start_val = down ? mod : '0;
   assign terminal  = down ? (count == '0) : (count == mod);

   // Counter register: load has priority over stepping.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values and simulation matches the synthesized flops.
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= start_val;
      end else if (enable) begin
         if (terminal)  count <= start_val;
         else if (down) count <= count - 1'b1;
         else           count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/loop_sequencer.sv
// Loop sequencer: runs L loops of an (M+1)-long up or down count after a start
// request, flagging the first and last cycle of each loop and pulsing done for
// one cycle at the end of the run.
// Optional feature: define LOOP_PAUSE_EN to add a pause input that freezes a
// run while high.
module loop_sequencer
   import loop_seq_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       down,
   input  logic [2:0] mod_value,
   input  logic [2:0] loops,
`ifdef LOOP_PAUSE_EN
   input  logic       pause,
`endif
   output logic [2:0] count,
   output logic [2:0] loop_idx,
   output logic       loopStart,
   output logic       loopEnd,
   output logic       busy,
   output logic       done
);

   state_t           state, state_nxt;
   logic             down_q;
   logic [CNT_W-1:0] mod_q;
   logic [CNT_W-1:0] loops_q;
   logic             run_act;
   logic             last_loop;
   logic             cnt_load;
   logic             cnt_en;
   logic             loop_inc;
   logic             cnt_down;
   logic [CNT_W-1:0] cnt_mod;
   logic             terminal;

   // A RUN cycle advances only when not paused.
`ifdef LOOP_PAUSE_EN
   assign run_act = (state == RUN) && !pause;
`else
   assign run_act = (state == RUN);
`endif

   // While idle the counter sees the live inputs so a load picks up the
   // values being latched on the same edge; afterwards it sees the latched ones.
   assign cnt_down  = (state == IDLE) ? down      : down_q;
   assign cnt_mod   = (state == IDLE) ? mod_value : mod_q;
   assign last_loop = ({1'b0, loop_idx} == (loops_count(loops_q) - 4'd1));

   mod_updown_cnt u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .enable   (cnt_en),
      .down     (cnt_down),
      .mod      (cnt_mod),
      .count    (count),
      .terminal (terminal)
   );

   // Next-state and counter control.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_nxt = state;
      cnt_load  = 1'b0;
      cnt_en    = 1'b0;
      loop_inc  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               cnt_load  = 1'b1;
            end
         end
         RUN: begin
            if (run_act) begin
               if (terminal && last_loop) begin
                  state_nxt = DONE;
               end else begin
                  cnt_en   = 1'b1;
                  loop_inc = terminal;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Run configuration captured when a start is accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         down_q  <= 1'b0;
         mod_q   <= '0;
         loops_q <= '0;
      end else if (cnt_load) begin
         down_q  <= down;
         mod_q   <= mod_value;
         loops_q <= loops;
      end
   end

   // Loop index: cleared at start, advanced on each non-final loop wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        loop_idx <= '0;
      else if (cnt_load) loop_idx <= '0;
      else if (loop_inc) loop_idx <= loop_idx + 1'b1;
   end

   assign loopStart = run_act && (count == (down_q ? mod_q : 3'd0));
   assign loopEnd   = run_act && terminal;
   assign busy      = (state == RUN) || (state == DONE);
   assign done      = (state == DONE);

endmodule

// File: tb/tb_loop_sequencer.sv
// Scoreboard bench for loop_sequencer. Each run's expected per-cycle outputs
// are generated from the loop/count rules and queued when start is issued;
// a negedge monitor pops and compares an entry for every busy cycle.
module tb_loop_sequencer;

   typedef struct packed {
      logic [2:0] cnt;
      logic [2:0] idx;
      logic       ls;
      logic       le;
      logic       dne;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       start;
   logic       down;
   logic [2:0] mod_value;
   logic [2:0] loops;
`ifdef LOOP_PAUSE_EN
   logic       pause;
`endif
   logic [2:0] count;
   logic [2:0] loop_idx;
   logic       loopStart;
   logic       loopEnd;
   logic       busy;
   logic       done;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;

   loop_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .down      (down),
      .mod_value (mod_value),
      .loops     (loops),
`ifdef LOOP_PAUSE_EN
      .pause     (pause),
`endif
      .count     (count),
      .loop_idx  (loop_idx),
      .loopStart (loopStart),
      .loopEnd   (loopEnd),
      .busy      (busy),
      .done      (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic pbit(input logic [31:0] pm, input int c);
      return (c < 32) ? pm[c[4:0]] : 1'b0;
   endfunction

   // Monitor: every busy cycle must match the next scoreboard entry.
   always @(negedge clk) begin
      if (reset === 1'b1 && busy === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("busy_without_expectation", {31'd0, busy}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("count",     {29'd0, count},     {29'd0, mon_e.cnt});
            check("loop_idx",  {29'd0, loop_idx},  {29'd0, mon_e.idx});
            check("loopStart", {31'd0, loopStart}, {31'd0, mon_e.ls});
            check("loopEnd",   {31'd0, loopEnd},   {31'd0, mon_e.le});
            check("done",      {31'd0, done},      {31'd0, mon_e.dne});
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_count"},     {29'd0, count},     32'd0);
      check({tag, "_loop_idx"},  {29'd0, loop_idx},  32'd0);
      check({tag, "_busy"},      {31'd0, busy},      32'd0);
      check({tag, "_done"},      {31'd0, done},      32'd0);
      check({tag, "_loopStart"}, {31'd0, loopStart}, 32'd0);
      check({tag, "_loopEnd"},   {31'd0, loopEnd},   32'd0);
   endtask

   // One run, entered and left at posedge+1. abort_at >= 0 pulls reset low
   // during that run cycle instead of completing.
   task automatic run_one(input logic dir, input logic [2:0] m, input logic [2:0] l,
                          input logic [31:0] pmask, input int abort_at);
      exp_t seq[$];
      exp_t e;
      exp_t last;
      int   lc;
      int   t;
      lc = (l == 3'd0) ? 8 : int'(l);
      // Visible sequence: each loop walks k = 0..M, counting k up or M-k down.
      for (int i = 0; i < lc; i++) begin
         for (int k = 0; k <= int'(m); k++) begin
            e.cnt = dir ? 3'(int'(m) - k) : 3'(k);
            e.idx = 3'(i);
            e.ls  = (k == 0);
            e.le  = (k == int'(m));
            e.dne = 1'b0;
            seq.push_back(e);
         end
      end
      // Paused cycles repeat the value about to be shown, with flags low.
      t = 0;
      last = seq[0];
      while (seq.size() > 0) begin
         if (pbit(pmask, t)) begin
            e = seq[0];
            e.ls = 1'b0;
            e.le = 1'b0;
            exp_q.push_back(e);
         end else begin
            last = seq.pop_front();
            exp_q.push_back(last);
         end
         t++;
      end
      e = last;
      e.ls  = 1'b0;
      e.le  = 1'b0;
      e.dne = 1'b1;
      exp_q.push_back(e);

      start     = 1'b1;
      down      = dir;
      mod_value = m;
      loops     = l;
`ifdef LOOP_PAUSE_EN
      pause     = 1'($urandom);
`endif
      @(posedge clk); #1;
      for (int c = 0; c < t; c++) begin
         start     = 1'($urandom);
         down      = 1'($urandom);
         mod_value = 3'($urandom);
         loops     = 3'($urandom);
`ifdef LOOP_PAUSE_EN
         pause     = pbit(pmask, c);
`endif
         if (c == abort_at) begin
            #1 reset = 1'b0;
            #1 check_reset_outputs("abort");
            exp_q.delete();
            start = 1'b0;
`ifdef LOOP_PAUSE_EN
            pause = 1'b0;
`endif
            @(posedge clk); #1;
            check_reset_outputs("abort_held");
            #3 reset = 1'b1;
            return;
         end
         @(posedge clk); #1;
      end
      // DONE cycle: start and pause must be ignored here.
      start = 1'($urandom);
`ifdef LOOP_PAUSE_EN
      pause = 1'($urandom);
`endif
      @(posedge clk); #1;
      start = 1'b0;
`ifdef LOOP_PAUSE_EN
      pause = 1'b0;
`endif
      check("idle_busy",      {31'd0, busy},      32'd0);
      check("idle_done",      {31'd0, done},      32'd0);
      check("idle_queue",     exp_q.size(),       32'd0);
      @(posedge clk); #1;
      check("idle_count",     {29'd0, count},     {29'd0, last.cnt});
      check("idle_loop_idx",  {29'd0, loop_idx},  {29'd0, last.idx});
      check("idle_loopStart", {31'd0, loopStart}, 32'd0);
      check("idle_loopEnd",   {31'd0, loopEnd},   32'd0);
   endtask

   initial begin
      logic [31:0] pm;
      reset     = 1'b0;
      start     = 1'b0;
      down      = 1'b0;
      mod_value = 3'd0;
      loops     = 3'd0;
`ifdef LOOP_PAUSE_EN
      pause     = 1'b0;
`endif
      #3 check_reset_outputs("reset");
      @(posedge clk); #1;
      reset = 1'b1;

      run_one(1'b0, 3'd5, 3'd2, 32'd0, -1);   // up, 12 RUN cycles, done in 13th
      run_one(1'b1, 3'd3, 3'd1, 32'd0, -1);   // down 3,2,1,0 then idle holds 0
      run_one(1'b0, 3'd0, 3'd3, 32'd0, -1);   // single-cycle loops
      run_one(1'b0, 3'd1, 3'd0, 32'd0, -1);   // loops=0 means 8
      run_one(1'b0, 3'd5, 3'd2, 32'd0, 3);    // reset in RUN cycle 4
      run_one(1'b1, 3'd4, 3'd2, 32'd0, -1);   // fresh start after abort
`ifdef LOOP_PAUSE_EN
      run_one(1'b0, 3'd2, 3'd2, 32'b10110, -1); // three pause cycles
`endif
      for (int r = 0; r < 20; r++) begin
         pm = 32'd0;
`ifdef LOOP_PAUSE_EN
         pm = $urandom & $urandom;
`endif
         run_one(1'($urandom), 3'($urandom), 3'($urandom), pm, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
